// File: rtl/svc_axi_pkg.sv
// svc_axi_pkg: shared AXI constants and the write-bridge state type.
//   AXI_BURST_*  : AWBURST encodings (FIXED / INCR / WRAP)
//   AXI_RESP_*   : BRESP encodings (OKAY / SLVERR)
//   state_t      : IDLE / BURST / RESP bridge states
//   clamp_size() : limits AWSIZE to the largest size the data bus carries
package svc_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    RESP  = 2'b10
  } state_t;

  // A beat can never advance the address by more than one bus word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    if (size > max_size) begin
      clamp_size = max_size;
    end else begin
      clamp_size = size;
    end
  endfunction

endpackage

// File: rtl/svc_axi_sram_if_wr.sv
// svc_axi_sram_if_wr: AXI4 write slave that turns every accepted W beat into
// one single-word SRAM write command.
//
// Ports
//   clk, rst_n                 : rising-edge clock, asynchronous active-low reset
//   s_axi_aw*                  : AXI write-address channel (one burst at a time)
//   s_axi_w*                   : AXI write-data channel (passed straight to SRAM in BURST)
//   s_axi_b*                   : AXI write-response channel (one response per burst)
//   sram_wr_cmd_*              : single-word SRAM write command (valid/ready)
//
// Optional feature macro: SVC_AXI_SRAM_IF_WR_SLVERR_EN
//   defined   -> WRAP (2'b10) and reserved (2'b11) bursts are swallowed: all W
//                beats are accepted, no SRAM command is issued, BRESP = SLVERR.
//   undefined -> every non-FIXED burst is handled as INCR, BRESP is always OKAY.
module svc_axi_sram_if_wr
  import svc_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int LSB             = $clog2(AXI_DATA_WIDTH) - 3,
  parameter int SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH - LSB,
  parameter int SRAM_DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int SRAM_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,

  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,

  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,

  output logic                          sram_wr_cmd_valid,
  input  logic                          sram_wr_cmd_ready,
  output logic [SRAM_ADDR_WIDTH-1:0]    sram_wr_cmd_addr,
  output logic [SRAM_DATA_WIDTH-1:0]    sram_wr_cmd_data,
  output logic [SRAM_STRB_WIDTH-1:0]    sram_wr_cmd_strb
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_awready;
  logic                      r_bvalid;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_remaining;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_last_beat;
  logic                      w_cmd_valid;
  logic                      w_wready;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_step;
  logic [1:0]                w_bresp;
  logic                      w_unused;

`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
  logic                      r_err;
`endif

  // Termination is driven purely by the beat count, so WLAST is not consulted.
  assign w_unused    = s_axi_wlast;

  assign w_aw_hs     = s_axi_awvalid && r_awready && (r_state == IDLE);
  assign w_w_hs      = s_axi_wvalid && w_wready;
  assign w_last_beat = w_w_hs && (r_remaining == 8'd0);
  assign w_addr_step = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << r_size;

`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
  assign w_bresp = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
  assign w_bresp = AXI_RESP_OKAY;
`endif

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_hs) begin
          w_next_state = BURST;
        end else begin
          w_next_state = IDLE;
        end
      end
      BURST: begin
        if (w_last_beat) begin
          w_next_state = RESP;
        end else begin
          w_next_state = BURST;
        end
      end
      RESP: begin
        if (r_bvalid && s_axi_bready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // W channel to SRAM command: zero-latency pass-through, gated to BURST.
  always_comb begin
    w_cmd_valid = 1'b0;
    w_wready    = 1'b0;
    if (r_state == BURST) begin
`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
      if (r_err) begin
        // Unsupported burst: drain the beats without touching the SRAM.
        w_cmd_valid = 1'b0;
        w_wready    = 1'b1;
      end else begin
        w_cmd_valid = s_axi_wvalid;
        w_wready    = sram_wr_cmd_ready;
      end
`else
      w_cmd_valid = s_axi_wvalid;
      w_wready    = sram_wr_cmd_ready;
`endif
    end else begin
      w_cmd_valid = 1'b0;
      w_wready    = 1'b0;
    end
  end

  // State register; AWREADY/BVALID are registered copies of the next state so
  // they line up exactly with entry into IDLE/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_awready <= (w_next_state == IDLE);
      r_bvalid  <= (w_next_state == RESP);
    end
  end

  // Burst context: captured on AW, advanced on every accepted W beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_remaining <= 8'd0;
      r_size      <= 3'd0;
      r_burst     <= 2'b00;
`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
      r_err       <= 1'b0;
`endif
    end else if (w_aw_hs) begin
      r_id        <= s_axi_awid;
      r_addr      <= s_axi_awaddr;
      r_remaining <= s_axi_awlen;
      r_size      <= clamp_size(s_axi_awsize, MAX_SIZE);
      r_burst     <= s_axi_awburst;
`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
      r_err       <= s_axi_awburst[1];
`endif
    end else if (w_w_hs) begin
      // Address wraps naturally at the top of the AXI address space.
      if (r_burst == AXI_BURST_FIXED) begin
        r_addr <= r_addr;
      end else begin
        r_addr <= r_addr + w_addr_step;
      end
      r_remaining <= r_remaining - 8'd1;
    end else begin
      r_addr      <= r_addr;
      r_remaining <= r_remaining;
    end
  end

  assign s_axi_awready     = r_awready;
  assign s_axi_wready      = w_wready;
  assign s_axi_bvalid      = r_bvalid;
  assign s_axi_bid         = r_id;
  assign s_axi_bresp       = w_bresp;
  assign sram_wr_cmd_valid = w_cmd_valid;
  assign sram_wr_cmd_addr  = r_addr[AXI_ADDR_WIDTH-1:LSB];
  assign sram_wr_cmd_data  = s_axi_wdata;
  assign sram_wr_cmd_strb  = s_axi_wstrb;

endmodule

// File: tb/tb_svc_axi_sram_if_wr.sv
// tb_svc_axi_sram_if_wr: randomized and directed stimulus for svc_axi_sram_if_wr
// with a transaction-level reference model (expected SRAM commands and B
// responses are queued when each burst is issued; a negedge monitor compares).
`timescale 1ns/1ps
module tb_svc_axi_sram_if_wr;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int LSB = 1;
  localparam int SAW = AW - LSB;
  localparam int SW  = DW / 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_axi_awvalid = 1'b0;
  logic           s_axi_awready;
  logic [IW-1:0]  s_axi_awid = '0;
  logic [AW-1:0]  s_axi_awaddr = '0;
  logic [7:0]     s_axi_awlen = 8'd0;
  logic [2:0]     s_axi_awsize = 3'd0;
  logic [1:0]     s_axi_awburst = 2'b00;
  logic           s_axi_wvalid = 1'b0;
  logic           s_axi_wready;
  logic [DW-1:0]  s_axi_wdata = '0;
  logic [SW-1:0]  s_axi_wstrb = '0;
  logic           s_axi_wlast = 1'b0;
  logic           s_axi_bvalid;
  logic           s_axi_bready = 1'b0;
  logic [IW-1:0]  s_axi_bid;
  logic [1:0]     s_axi_bresp;
  logic           sram_wr_cmd_valid;
  logic           sram_wr_cmd_ready = 1'b0;
  logic [SAW-1:0] sram_wr_cmd_addr;
  logic [DW-1:0]  sram_wr_cmd_data;
  logic [SW-1:0]  sram_wr_cmd_strb;

  always #5 clk = ~clk;

  svc_axi_sram_if_wr dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axi_awvalid     (s_axi_awvalid),
    .s_axi_awready     (s_axi_awready),
    .s_axi_awid        (s_axi_awid),
    .s_axi_awaddr      (s_axi_awaddr),
    .s_axi_awlen       (s_axi_awlen),
    .s_axi_awsize      (s_axi_awsize),
    .s_axi_awburst     (s_axi_awburst),
    .s_axi_wvalid      (s_axi_wvalid),
    .s_axi_wready      (s_axi_wready),
    .s_axi_wdata       (s_axi_wdata),
    .s_axi_wstrb       (s_axi_wstrb),
    .s_axi_wlast       (s_axi_wlast),
    .s_axi_bvalid      (s_axi_bvalid),
    .s_axi_bready      (s_axi_bready),
    .s_axi_bid         (s_axi_bid),
    .s_axi_bresp       (s_axi_bresp),
    .sram_wr_cmd_valid (sram_wr_cmd_valid),
    .sram_wr_cmd_ready (sram_wr_cmd_ready),
    .sram_wr_cmd_addr  (sram_wr_cmd_addr),
    .sram_wr_cmd_data  (sram_wr_cmd_data),
    .sram_wr_cmd_strb  (sram_wr_cmd_strb)
  );

  int cmp_total = 0;
  int cmp_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word address of beat n of a burst, in closed form.
  function automatic logic [SAW-1:0] beat_word(input logic [AW-1:0] base, input int n,
                                               input logic [2:0] size, input logic [1:0] burst);
    int eff;
    logic [AW-1:0] a;
    eff = (size > 3'd1) ? 1 : int'(size);
    if (burst == 2'b00) a = base;
    else a = AW'(int'(base) + n * (1 << eff));
    return a[AW-1:LSB];
  endfunction

  function automatic bit is_err_burst(input logic [1:0] burst);
`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
    return burst[1];
`else
    return 1'b0;
`endif
  endfunction

  // Expected traffic, pushed by the driver when a burst is issued.
  logic [SAW-1:0] q_addr[$];
  logic [DW-1:0]  q_data[$];
  logic [SW-1:0]  q_strb[$];
  logic [IW-1:0]  q_bid[$];
  logic [1:0]     q_bresp[$];

  // Monitor-owned model of protocol phase.
  int             m_beats_left = 0;
  bit             m_b_pending  = 1'b0;
  bit             m_err        = 1'b0;
  int             m_since_rel  = 0;
  int             b_count      = 0;
  int             cmd_count    = 0;
  logic [SAW-1:0] last_cmd_addr = '0;
  logic [IW-1:0]  last_bid      = '0;

  always @(posedge clk) begin
    if (!rst_n) m_since_rel = 0;
    else if (m_since_rel < 2) m_since_rel = m_since_rel + 1;
  end

  always @(negedge clk) begin
    bit exp_aw, exp_cv, exp_wr, exp_bv;
    if (!rst_n) begin
      check("rst_awready", {31'd0, s_axi_awready}, 32'd0);
      check("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
      check("rst_cmd_valid", {31'd0, sram_wr_cmd_valid}, 32'd0);
      check("rst_wready",  {31'd0, s_axi_wready},  32'd0);
      m_beats_left = 0;
      m_b_pending  = 1'b0;
      m_err        = 1'b0;
    end else begin
      exp_aw = (m_since_rel >= 1) && (m_beats_left == 0) && !m_b_pending;
      exp_cv = (m_beats_left > 0) && s_axi_wvalid && !m_err;
      exp_wr = (m_beats_left > 0) && (m_err || sram_wr_cmd_ready);
      exp_bv = m_b_pending;
      check("awready",   {31'd0, s_axi_awready},     {31'd0, exp_aw});
      check("cmd_valid", {31'd0, sram_wr_cmd_valid}, {31'd0, exp_cv});
      check("wready",    {31'd0, s_axi_wready},      {31'd0, exp_wr});
      check("bvalid",    {31'd0, s_axi_bvalid},      {31'd0, exp_bv});
      if (exp_cv && sram_wr_cmd_ready) begin
        if (q_addr.size() == 0) begin
          check("cmd_queue_empty", 32'd1, 32'd0);
        end else begin
          check("cmd_addr", {13'd0, sram_wr_cmd_addr}, {13'd0, q_addr[0]});
          check("cmd_data", {16'd0, sram_wr_cmd_data}, {16'd0, q_data[0]});
          check("cmd_strb", {30'd0, sram_wr_cmd_strb}, {30'd0, q_strb[0]});
          last_cmd_addr = sram_wr_cmd_addr;
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          void'(q_strb.pop_front());
          cmd_count++;
        end
      end
      if (exp_bv) begin
        if (q_bid.size() == 0) begin
          check("b_queue_empty", 32'd1, 32'd0);
        end else begin
          check("bid",   {28'd0, s_axi_bid},   {28'd0, q_bid[0]});
          check("bresp", {30'd0, s_axi_bresp}, {30'd0, q_bresp[0]});
          if (s_axi_bready) begin
            last_bid = s_axi_bid;
            void'(q_bid.pop_front());
            void'(q_bresp.pop_front());
          end
        end
      end
      // Advance the phase model using the handshakes the spec allows.
      if (s_axi_awvalid && exp_aw) begin
        m_beats_left = int'(s_axi_awlen) + 1;
        m_err        = is_err_burst(s_axi_awburst);
      end else if (s_axi_wvalid && exp_wr) begin
        m_beats_left = m_beats_left - 1;
        if (m_beats_left == 0) m_b_pending = 1'b1;
      end
      if (exp_bv && s_axi_bready) begin
        m_b_pending = 1'b0;
        b_count++;
      end
    end
  end

  // Backpressure: random by default, scripted pattern when rdy_mode == 1.
  int rdy_mode = 0;
  int bv_cnt   = 0;
  always @(posedge clk) begin
    #1;
    if (s_axi_bvalid) bv_cnt = bv_cnt + 1;
    else bv_cnt = 0;
    if (rdy_mode == 0) begin
      sram_wr_cmd_ready = ($urandom_range(0, 3) != 0);
      s_axi_bready      = ($urandom_range(0, 2) != 0);
    end else begin
      sram_wr_cmd_ready = ~sram_wr_cmd_ready;
      s_axi_bready      = (bv_cnt > 5);
    end
  end

  // Issue one burst; abort_after > 0 pulls rst_n low right after that many beats.
  task automatic do_txn(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input bit rnd_data, input logic [DW-1:0] d0, input int abort_after);
    logic [DW-1:0] d[$];
    logic [SW-1:0] s[$];
    int  w_idx, b_start, guard;
    bit  aw_done, aw_hs, w_hs;
    for (int i = 0; i <= int'(len); i++) begin
      d.push_back(rnd_data ? DW'($urandom) : DW'(d0 + DW'(i)));
      s.push_back(rnd_data ? SW'($urandom) : 2'b11);
      if (!is_err_burst(burst)) begin
        q_addr.push_back(beat_word(addr, i, size, burst));
        q_data.push_back(d[i]);
        q_strb.push_back(s[i]);
      end
    end
    q_bid.push_back(id);
    q_bresp.push_back(is_err_burst(burst) ? 2'b10 : 2'b00);
    b_start = b_count;
    s_axi_awvalid = 1'b1;
    s_axi_awid    = id;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = size;
    s_axi_awburst = burst;
    aw_done = 1'b0;
    w_idx   = 0;
    guard   = 0;
    while (!(aw_done && w_idx > int'(len)) && guard < 3000) begin
      if (!s_axi_wvalid && w_idx <= int'(len)) begin
        s_axi_wvalid = ($urandom_range(0, 3) != 0);
        s_axi_wdata  = d[w_idx];
        s_axi_wstrb  = s[w_idx];
        s_axi_wlast  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk);
      #1;
      guard++;
      if (aw_hs) begin
        s_axi_awvalid = 1'b0;
        aw_done = 1'b1;
      end
      if (w_hs) begin
        s_axi_wvalid = 1'b0;
        w_idx++;
        if (abort_after > 0 && w_idx == abort_after) begin
          rst_n = 1'b0;
          s_axi_awvalid = 1'b0;
          q_addr.delete(); q_data.delete(); q_strb.delete();
          q_bid.delete();  q_bresp.delete();
          return;
        end
      end
    end
    if (guard >= 3000) check("w_timeout", 32'd1, 32'd0);
    guard = 0;
    while (b_count == b_start && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 500) check("b_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int c0;
    // Pin the reference address arithmetic with hand-computed values.
    check("model_single",   {13'd0, beat_word(20'h00010, 0, 3'd1, 2'b01)}, 32'h00008);
    for (int i = 0; i < 4; i++)
      check("model_incr",   {13'd0, beat_word(20'h00100, i, 3'd1, 2'b01)}, 32'h00080 + i);
    check("model_fixed",    {13'd0, beat_word(20'h00040, 2, 3'd1, 2'b00)}, 32'h00020);
    check("model_wrap_top", {13'd0, beat_word(20'hFFFFE, 1, 3'd1, 2'b01)}, 32'h00000);
    check("model_clamp",    {13'd0, beat_word(20'h00100, 1, 3'd3, 2'b01)}, 32'h00081);
    check("model_byte",     {13'd0, beat_word(20'h00101, 1, 3'd0, 2'b01)}, 32'h00081);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single beat.
    c0 = cmd_count;
    do_txn(4'h5, 20'h00010, 8'd0, 3'd1, 2'b01, 1'b0, 16'hBEEF, 0);
    check("single_cmd_count", cmd_count - c0, 32'd1);
    check("single_cmd_addr", {13'd0, last_cmd_addr}, 32'h00008);
    check("single_bid", {28'd0, last_bid}, 32'h5);

    // INCR, four beats.
    c0 = cmd_count;
    do_txn(4'hA, 20'h00100, 8'd3, 3'd1, 2'b01, 1'b0, 16'h1000, 0);
    check("incr_cmd_count", cmd_count - c0, 32'd4);
    check("incr_last_addr", {13'd0, last_cmd_addr}, 32'h00083);

    // FIXED, three beats.
    c0 = cmd_count;
    do_txn(4'h3, 20'h00040, 8'd2, 3'd1, 2'b00, 1'b0, 16'h2000, 0);
    check("fixed_cmd_count", cmd_count - c0, 32'd3);
    check("fixed_last_addr", {13'd0, last_cmd_addr}, 32'h00020);

    // Scripted backpressure: ready toggles, bready held low for 5 cycles.
    rdy_mode = 1;
    c0 = cmd_count;
    do_txn(4'h7, 20'h00200, 8'd3, 3'd1, 2'b01, 1'b1, 16'h0000, 0);
    check("bp_cmd_count", cmd_count - c0, 32'd4);
    rdy_mode = 0;

    // Address wrap at the top of the space.
    do_txn(4'h1, 20'hFFFFC, 8'd3, 3'd1, 2'b01, 1'b1, 16'h0000, 0);

`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
    c0 = cmd_count;
    do_txn(4'h9, 20'h00300, 8'd1, 3'd1, 2'b10, 1'b1, 16'h0000, 0);
    check("slverr_cmd_count", cmd_count - c0, 32'd0);
`endif

    // Reset after the 2nd of 4 beats abandons the burst.
    c0 = cmd_count;
    do_txn(4'hC, 20'h00400, 8'd3, 3'd1, 2'b01, 1'b1, 16'h0000, 2);
    check("abort_cmd_count", cmd_count - c0, 32'd2);
    s_axi_wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    c0 = cmd_count;
    do_txn(4'hD, 20'h00500, 8'd0, 3'd1, 2'b01, 1'b0, 16'h5A5A, 0);
    check("post_reset_cmd_count", cmd_count - c0, 32'd1);
    check("post_reset_bid", {28'd0, last_bid}, 32'hD);

    // Randomized bursts.
    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'(20'hFFFF0 + 20'($urandom_range(0, 15))) : AW'($urandom);
      do_txn(IW'($urandom), a, 8'($urandom_range(0, 12)), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 1'b1, 16'h0000, 0);
    end

    repeat (4) @(posedge clk);
    check("cmd_queue_drained", q_addr.size(), 32'd0);
    check("b_queue_drained", q_bid.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $finish;
  end

  initial begin
    #2000000;
    cmp_fail++;
    $display("FAIL global_timeout: simulation time limit reached at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/svc_axi_sram_if_wr.md
SVC_AXI_SRAM_IF_WR -- requirements
Module: svc_axi_sram_if_wr

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 20, AXI byte-address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 16, AXI data width (power of 2, >=8).
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter LSB, default $clog2(AXI_DATA_WIDTH)-3, byte-to-word shift.
REQ-005 SHALL have parameter SRAM_ADDR_WIDTH, default AXI_ADDR_WIDTH-LSB, word-address width.
REQ-006 SHALL have parameter SRAM_DATA_WIDTH, default AXI_DATA_WIDTH; SRAM_STRB_WIDTH, default AXI_DATA_WIDTH/8.
REQ-007 SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-008 s_axi_awvalid/awready in/out 1; awid in AXI_ID_WIDTH; awaddr in AXI_ADDR_WIDTH; awlen in 8; awsize in 3; awburst in 2: AXI AW channel.
REQ-009 s_axi_wvalid/wready in/out 1; wdata in AXI_DATA_WIDTH; wstrb in AXI_DATA_WIDTH/8; wlast in 1: AXI W channel.
REQ-010 s_axi_bvalid/bready out/in 1; bid out AXI_ID_WIDTH; bresp out 2: AXI B channel.
REQ-011 sram_wr_cmd_valid out 1; sram_wr_cmd_ready in 1; sram_wr_cmd_addr out SRAM_ADDR_WIDTH; sram_wr_cmd_data out SRAM_DATA_WIDTH; sram_wr_cmd_strb out SRAM_STRB_WIDTH: single-word SRAM write command.

Function
REQ-012 SHALL implement states IDLE, BURST, RESP; reset state IDLE.
REQ-013 IDLE: awready SHALL be registered-high; on awvalid&&awready capture id, addr, awlen as remaining, size clamped to $clog2(AXI_DATA_WIDTH/8), burst; drop awready; go BURST next cycle.
REQ-014 BURST: sram_wr_cmd_valid = s_axi_wvalid, s_axi_wready = sram_wr_cmd_ready (combinational pass-through, zero latency); both SHALL be 0 outside BURST.
REQ-015 sram_wr_cmd_addr = addr[AXI_ADDR_WIDTH-1:LSB]; data/strb = wdata/wstrb unmodified.
REQ-016 Per accepted beat: addr += (1<<size) unless burst==FIXED (2'b00); addr wraps modulo 2^AXI_ADDR_WIDTH; remaining decrements.
REQ-017 Beat with remaining==0 SHALL end burst -> RESP; remaining count is authoritative, wlast ignored for termination.
REQ-018 RESP: bvalid registered-high the cycle after final beat, bid = captured id, bresp = 2'b00 (see REQ-025); hold until bready.
REQ-019 bvalid&&bready -> IDLE; awready SHALL re-assert in the same cycle state returns to IDLE.
REQ-020 No W beat SHALL be accepted in IDLE or RESP; AW and W arriving same cycle: AW accepted first, W accepted from next cycle.
REQ-021 sram_wr_cmd_valid SHALL never deassert while valid and not ready (inherits wvalid AXI stability).

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, awready 0, bvalid 0, thus sram_wr_cmd_valid 0 and wready 0.
REQ-023 awready SHALL rise on the first clock after rst_n deasserts.
REQ-024 Reset mid-burst or mid-RESP SHALL abandon the transaction with no further commands and no B response.

Configuration
REQ-025 Macro SVC_AXI_SRAM_IF_WR_SLVERR_EN: defined -> awburst==2'b10 (WRAP) or 2'b11 consumes all W beats with sram_wr_cmd_valid held 0, bresp=2'b10 SLVERR; undefined -> non-FIXED treated as INCR, bresp always 2'b00.

Structure
REQ-026 AXI burst (FIXED/INCR/WRAP) and resp (OKAY/SLVERR) constants and the state_t enum SHALL live in shared package svc_axi_pkg.
REQ-027 No sub-module required; optional svc_skidbuf on W path permitted only if REQ-014 zero-latency is relaxed by spec change.

Verification
REQ-028 awaddr=0x0010, awlen=0, data 0xBEEF strb 2'b11 -> one cmd addr 0x0008 data 0xBEEF, then bresp 0, bid matches.
REQ-029 INCR awaddr=0x0100 awlen=3 -> cmd addrs 0x080,0x081,0x082,0x083, single B after 4th beat.
REQ-030 FIXED awaddr=0x0040 awlen=2 -> three cmds all addr 0x020.
REQ-031 sram_wr_cmd_ready toggling 1-0-1 and bready held low 5 cycles -> no beat lost/duplicated, bvalid stable, awready low until B handshake.
REQ-032 rst_n asserted after 2nd of 4 beats -> bvalid 0, no further cmds; new AW accepted one cycle after release.
REQ-033 With SVC_AXI_SRAM_IF_WR_SLVERR_EN, WRAP awlen=1 -> zero SRAM cmds, 2 W beats consumed, bresp 2'b10.
